// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS control sequencer.
// Steps fetch/decode/execute/memory/writeback for each instruction and drives the
// datapath enables and mux selects. FETCH, MEMRD and MEMWR wait on the mem_ready
// handshake. A wait counter turns a stuck bus into a sticky bus_err and a HALT.
// Optional build macro: ILLEGAL_TRAP_EN. When it is defined, an unlisted opcode
// traps in TRAP. When it is undefined, an unlisted opcode behaves as a NOP.
//
// Handshake: a request (mem_re or mem_we) is held while the FSM is in
// FETCH/MEMRD/MEMWR. The access completes in the cycle where the request and
// mem_ready are both high, and the FSM leaves the state on the next edge.
// mem_ready is ignored in every other state.
module mc_control_fsm #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_re,
  output logic       mem_we,
  output logic       ir_we,
  output logic       ext_zero,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_we,
  output logic       bus_err,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  // The wait counter compares against TIMEOUT-1, so the timeout fires on the
  // TIMEOUT-th consecutive cycle without mem_ready.
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait;
  logic       r_bus_err;
  logic       w_in_wait;
  logic       w_timeout;
  logic       w_zext_op;
  logic       w_pc_we;
  logic       w_mem_re;
  logic       w_mem_we;
  logic       w_ir_we;

  assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout = w_in_wait && !mem_ready && (r_wait == LP_WAIT_LAST);
  // andi/ori/xori zero-extend their immediate. All other immediate ops sign-extend.
  assign w_zext_op = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);

  // Next-state selection from the current state, opcode and handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_timeout)      w_next = S_HALT;
        else if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == 6'h00)                           w_next = S_EXEC_R;
        else if (opcode == 6'h23 || opcode == 6'h2B)   w_next = S_MEMADR;
        else if (opcode == 6'h04 || opcode == 6'h05)   w_next = S_BRANCH;
        else if (opcode == 6'h02)                      w_next = S_JUMP;
        else if (opcode[5:3] == 3'b001)                w_next = S_EXEC_I;
        else if (opcode == 6'h3F)                      w_next = S_HALT;
        else begin
`ifdef ILLEGAL_TRAP_EN
          w_next = S_TRAP;
`else
          w_next = S_FETCH;
`endif
        end
      end
      S_MEMADR: begin
        if (opcode == 6'h2B)      w_next = S_MEMWR;
        else if (opcode == 6'h23) w_next = S_MEMRD;
        else                      w_next = S_FETCH;
      end
      S_MEMRD: begin
        if (w_timeout)      w_next = S_HALT;
        else if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWR: begin
        if (w_timeout)      w_next = S_HALT;
        else if (mem_ready) w_next = S_FETCH;
      end
      S_MEMWB:  w_next = S_FETCH;
      S_EXEC_R: w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_EXEC_I: w_next = S_IWB;
      S_IWB:    w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  // Datapath controls are decoded from the state register. The only input
  // terms are the handshake in FETCH, the branch condition, and the opcode,
  // which the IR holds stable.
  always_comb begin
    w_pc_we    = 1'b0;
    pc_src     = 2'd0;
    iord       = 1'b0;
    w_mem_re   = 1'b0;
    w_mem_we   = 1'b0;
    w_ir_we    = 1'b0;
    ext_zero   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_we     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_re  = 1'b1;
        w_ir_we   = mem_ready;
        w_pc_we   = mem_ready;
        alu_src_b = 2'd1;
      end
      S_DECODE: alu_src_b = 2'd3;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        w_mem_re = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_we     = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        w_mem_we = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
      end
      S_RWB: begin
        reg_dst = 1'b1;
        reg_we  = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = 2'd3;
        ext_zero  = w_zext_op;
      end
      S_IWB: begin
        reg_we   = 1'b1;
        ext_zero = w_zext_op;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_src    = 2'd1;
        w_pc_we   = (opcode == 6'h04) ? alu_zero : ~alu_zero;
      end
      S_JUMP: begin
        pc_src  = 2'd2;
        w_pc_we = 1'b1;
      end
      default: ;
    endcase
  end

  // The reset state is FETCH, which raises mem_re. Gating with rst_n makes an
  // asserted reset drop every request and write strobe at once, without
  // waiting for a clock edge.
  assign mem_re  = w_mem_re & rst_n;
  assign mem_we  = w_mem_we & rst_n;
  assign ir_we   = w_ir_we  & rst_n;
  assign pc_we   = w_pc_we  & rst_n;
  assign bus_err = r_bus_err;
  assign state_o = r_state;

  // State register, wait counter and sticky bus error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_wait    <= 8'd0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counting only while the FSM stays in a request state clears the
      // counter on every entry to FETCH/MEMRD/MEMWR.
      if (w_in_wait && (w_next == r_state)) r_wait <= r_wait + 8'd1;
      else                                  r_wait <= 8'd0;
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: checks mc_control_fsm against an instruction-level model.
// Each instruction becomes a queue of per-cycle records. Each record holds the
// inputs to drive and the outputs the instruction must show in that cycle.
// One compare process checks every cycle. Literal checks pin the model.
module tb_mc_control_fsm;

  localparam int TO = 16;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC_R = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_EXEC_I = 4'd8;
  localparam logic [3:0] S_IWB    = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_re;
  logic       mem_we;
  logic       ir_we;
  logic       ext_zero;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_we;
  logic       bus_err;
  logic [3:0] state_o;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       ir_we;
    logic       ext_zero;
    logic       a;
    logic [1:0] b;
    logic [1:0] alu_op;
    logic       dst;
    logic       m2r;
    logic       reg_we;
    logic       bus_err;
  } out_t;

  typedef struct packed {
    logic mr;
    logic az;
    out_t e;
  } cyc_t;

  localparam int CW = $bits(cyc_t);

  logic [CW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  out_t          cur_exp;
  out_t          act_o;
  bit            chk_en = 1'b0;

  // Per-instruction trace gathered by the compare process.
  logic [31:0] tr_pack;
  int          cnt_mem_re, cnt_memrd_re, cnt_reg_we, cnt_ez, cnt_pc_we, cnt_ir_we, cnt_mem_we;
  logic [3:0]  last_st;
  logic        last_bus_err;

  mc_control_fsm #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .iord       (iord),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .ir_we      (ir_we),
    .ext_zero   (ext_zero),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_we     (reg_we),
    .bus_err    (bus_err),
    .state_o    (state_o)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic rand_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic out_t blank(input logic [3:0] st);
    out_t o;
    o    = '0;
    o.st = st;
    return o;
  endfunction

  task automatic push(input out_t o, input logic mr, input logic az);
    cyc_t c;
    c.mr = mr;
    c.az = az;
    c.e  = o;
    exp_q.push_back(c);
  endtask

  // In cycles where mem_ready and alu_zero are ignored, drive them at random.
  task automatic push_free(input out_t o);
    push(o, rand_bit(), rand_bit());
  endtask

  task automatic push_stuck(input logic [3:0] st, input logic berr);
    out_t o;
    for (int k = 0; k < 3; k++) begin
      o         = blank(st);
      o.bus_err = berr;
      push_free(o);
    end
  endtask

  // A request phase is w cycles without mem_ready, then one cycle that completes
  // the access. If TO cycles pass without mem_ready, the bus is stuck: the
  // request drops and the FSM parks in HALT with bus_err set.
  task automatic req_phase(input logic [3:0] st, input int w, output bit to);
    out_t o;
    int   i;
    bit   done;
    i    = 0;
    done = 1'b0;
    to   = 1'b0;
    while (!done) begin
      o = blank(st);
      if (st == S_FETCH) begin
        o.mem_re = 1'b1;
        o.b      = 2'd1;
      end else begin
        o.iord = 1'b1;
        if (st == S_MEMRD) o.mem_re = 1'b1;
        else               o.mem_we = 1'b1;
      end
      if (i >= w) begin
        if (st == S_FETCH) begin
          o.ir_we = 1'b1;
          o.pc_we = 1'b1;
        end
        push(o, 1'b1, rand_bit());
        done = 1'b1;
      end else begin
        push(o, 1'b0, rand_bit());
        if (i + 1 == TO) begin
          to   = 1'b1;
          done = 1'b1;
          push_stuck(S_HALT, 1'b1);
        end
      end
      i++;
    end
  endtask

  // Instruction-level model. It lists the cycles one instruction takes.
  task automatic build(input logic [5:0] opc, input logic az, input int wf, input int wm,
                       output bit hlt);
    out_t o;
    bit   to;
    logic ez;
    hlt = 1'b0;
    req_phase(S_FETCH, wf, to);
    if (to) begin
      hlt = 1'b1;
      return;
    end
    o   = blank(S_DECODE);
    o.b = 2'd3;
    push_free(o);
    if (opc == 6'h00) begin
      o = blank(S_EXEC_R); o.a = 1'b1; o.alu_op = 2'd2; push_free(o);
      o = blank(S_RWB); o.dst = 1'b1; o.reg_we = 1'b1; push_free(o);
    end else if (opc == 6'h23 || opc == 6'h2B) begin
      o = blank(S_MEMADR); o.a = 1'b1; o.b = 2'd2; push_free(o);
      if (opc == 6'h23) begin
        req_phase(S_MEMRD, wm, to);
        if (to) hlt = 1'b1;
        else begin
          o = blank(S_MEMWB); o.m2r = 1'b1; o.reg_we = 1'b1; push_free(o);
        end
      end else begin
        req_phase(S_MEMWR, wm, to);
        hlt = to;
      end
    end else if (opc == 6'h04 || opc == 6'h05) begin
      o = blank(S_BRANCH); o.a = 1'b1; o.alu_op = 2'd1; o.pc_src = 2'd1;
      o.pc_we = (opc == 6'h04) ? az : ~az;
      push(o, rand_bit(), az);
    end else if (opc == 6'h02) begin
      o = blank(S_JUMP); o.pc_src = 2'd2; o.pc_we = 1'b1; push_free(o);
    end else if (opc >= 6'h08 && opc <= 6'h0F) begin
      ez = (opc >= 6'h0C && opc <= 6'h0E);
      o = blank(S_EXEC_I); o.a = 1'b1; o.b = 2'd2; o.alu_op = 2'd3; o.ext_zero = ez; push_free(o);
      o = blank(S_IWB); o.reg_we = 1'b1; o.ext_zero = ez; push_free(o);
    end else if (opc == 6'h3F) begin
      push_stuck(S_HALT, 1'b0);
      hlt = 1'b1;
    end else begin
`ifdef ILLEGAL_TRAP_EN
      push_stuck(S_TRAP, 1'b0);
      hlt = 1'b1;
`endif
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_trace();
    tr_pack      = '0;
    cnt_mem_re   = 0;
    cnt_memrd_re = 0;
    cnt_reg_we   = 0;
    cnt_ez       = 0;
    cnt_pc_we    = 0;
    cnt_ir_we    = 0;
    cnt_mem_we   = 0;
    last_st      = 4'hF;
    last_bus_err = 1'b0;
  endtask

  // Driver: applies queued cycles. It is entered and left at posedge+1.
  // Cycles beyond max_cyc are dropped so the caller can abort mid-access.
  task automatic run(input int max_cyc);
    cyc_t c;
    int   n;
    n = 0;
    while (exp_q.size() > 0) begin
      c = cyc_t'(exp_q.pop_front());
      if (n < max_cyc) begin
        mem_ready = c.mr;
        alu_zero  = c.az;
        cur_exp   = c.e;
        chk_en    = 1'b1;
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk_en = 1'b0;
  endtask

  // Asserts reset at posedge+1 and releases it at a later posedge+1.
  // The FSM is then in its first FETCH cycle.
  task automatic do_reset();
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rst_state",   32'(state_o), 32'd0);
    check("rst_mem_re",  32'(mem_re),  32'd0);
    check("rst_mem_we",  32'(mem_we),  32'd0);
    check("rst_pc_we",   32'(pc_we),   32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] opc, input logic az, input int wf, input int wm);
    bit hlt;
    opcode = opc;
    clear_trace();
    build(opc, az, wf, wm, hlt);
    run(1000);
    if (hlt) do_reset();
  endtask

  // Scoreboard compare: checks every active cycle against the model at negedge.
  always @(negedge clk) begin
    if (chk_en) begin
      act_o.st       = state_o;
      act_o.pc_we    = pc_we;
      act_o.pc_src   = pc_src;
      act_o.iord     = iord;
      act_o.mem_re   = mem_re;
      act_o.mem_we   = mem_we;
      act_o.ir_we    = ir_we;
      act_o.ext_zero = ext_zero;
      act_o.a        = alu_src_a;
      act_o.b        = alu_src_b;
      act_o.alu_op   = alu_op;
      act_o.dst      = reg_dst;
      act_o.m2r      = mem_to_reg;
      act_o.reg_we   = reg_we;
      act_o.bus_err  = bus_err;
      n_tests++;
      if (act_o !== cur_exp) begin
        n_fail++;
        $display("FAIL cycle_outputs op=%h actual=%h expected=%h (state act=%0d exp=%0d) t=%0t",
                 opcode, act_o, cur_exp, act_o.st, cur_exp.st, $time);
      end
      tr_pack = {tr_pack[27:0], state_o};
      if (mem_re) cnt_mem_re++;
      if (mem_re && state_o == S_MEMRD) cnt_memrd_re++;
      if (mem_we) cnt_mem_we++;
      if (reg_we) cnt_reg_we++;
      if (ext_zero) cnt_ez++;
      if (pc_we) cnt_pc_we++;
      if (ir_we) cnt_ir_we++;
      last_st      = state_o;
      last_bus_err = bus_err;
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  logic [5:0] ops_tbl[12];

  initial begin
    int   wf;
    int   wm;
    logic [5:0] opc;
    ops_tbl   = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                  6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F};
    rst_n     = 1'b0;
    opcode    = 6'h00;
    alu_zero  = 1'b0;
    mem_ready = 1'b0;
    clear_trace();
    @(posedge clk);
    #1;
    do_reset();

    // Reset into FETCH with an immediate mem_ready, then an R-type instruction.
    run_instr(6'h00, 1'b0, 0, 0);
    check("rtype_trace", tr_pack, 32'h0000_0167);
    check("rtype_pc_we", 32'(cnt_pc_we), 32'd1);
    check("rtype_ir_we", 32'(cnt_ir_we), 32'd1);

    // Zero-extended versus sign-extended immediate.
    run_instr(6'h0D, 1'b0, 0, 0);
    check("ori_trace", tr_pack, 32'h0000_0189);
    check("ori_ext_zero_cycles", 32'(cnt_ez), 32'd2);
    check("ori_reg_we_cycles", 32'(cnt_reg_we), 32'd1);
    run_instr(6'h08, 1'b0, 0, 0);
    check("addi_trace", tr_pack, 32'h0000_0189);
    check("addi_ext_zero_cycles", 32'(cnt_ez), 32'd0);

    // Load with three stall cycles.
    run_instr(6'h23, 1'b0, 0, 3);
    check("lw_trace", tr_pack, 32'h0123_3334);
    check("lw_memrd_re_cycles", 32'(cnt_memrd_re), 32'd4);
    check("lw_reg_we_cycles", 32'(cnt_reg_we), 32'd1);

    // Branches taken and not taken.
    run_instr(6'h04, 1'b1, 0, 0);
    check("beq_trace", tr_pack, 32'h0000_001A);
    check("beq_pc_we_cycles", 32'(cnt_pc_we), 32'd2);
    run_instr(6'h05, 1'b1, 1, 0);
    check("bne_pc_we_cycles", 32'(cnt_pc_we), 32'd1);

    // Store and jump.
    run_instr(6'h2B, 1'b0, 2, 1);
    check("sw_mem_we_cycles", 32'(cnt_mem_we), 32'd2);
    run_instr(6'h02, 1'b0, 0, 0);
    check("j_trace", tr_pack, 32'h0000_001B);

    // Last-chance mem_ready on the TO-th cycle still completes.
    run_instr(6'h00, 1'b0, TO - 1, 0);
    check("fetch_edge_bus_err", 32'(last_bus_err), 32'd0);
    check("fetch_edge_last_state", 32'(last_st), 32'(S_RWB));

    // Stuck bus in FETCH: a timeout, then HALT with a sticky bus_err.
    run_instr(6'h00, 1'b0, TO + 3, 0);
    check("timeout_fetch_req_cycles", 32'(cnt_mem_re), 32'd16);
    check("timeout_fetch_state", 32'(last_st), 32'(S_HALT));
    check("timeout_fetch_bus_err", 32'(last_bus_err), 32'd1);

    // Stuck bus in MEMWR.
    run_instr(6'h2B, 1'b0, 0, TO + 1);
    check("timeout_memwr_we_cycles", 32'(cnt_mem_we), 32'd16);
    check("timeout_memwr_bus_err", 32'(last_bus_err), 32'd1);

    // HALT instruction.
    run_instr(6'h3F, 1'b0, 0, 0);
    check("halt_state", 32'(last_st), 32'(S_HALT));
    check("halt_bus_err", 32'(last_bus_err), 32'd0);

    // Unlisted opcode.
    run_instr(6'h3A, 1'b0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    check("illegal_state", 32'(last_st), 32'(S_TRAP));
`else
    check("illegal_trace", tr_pack, 32'h0000_0001);
    check("illegal_reg_we", 32'(cnt_reg_we + cnt_mem_we), 32'd0);
`endif

    // A reset during a store in progress drops mem_we without a clock edge.
    opcode = 6'h2B;
    clear_trace();
    begin
      bit hlt;
      build(6'h2B, 1'b0, 0, 10, hlt);
    end
    run(5);
    check("pre_reset_mem_we", 32'(mem_we), 32'd1);
    do_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 7) == 0) opc = 6'($urandom_range(0, 63));
      else                           opc = ops_tbl[$urandom_range(0, 11)];
      wf = ($urandom_range(0, 19) == 0) ? (TO - 1 + int'($urandom_range(0, 2))) : int'($urandom_range(0, 3));
      wm = ($urandom_range(0, 19) == 0) ? (TO - 1 + int'($urandom_range(0, 2))) : int'($urandom_range(0, 3));
      run_instr(opc, rand_bit(), wf, wm);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
